bit_down_counter: RTL and testbench
===================================

# bit_down_counter

Synchronous, parameterised down counter with parallel load, count enable, one-shot and auto-reload modes, and a terminal-count pulse. It is the decrementing counterpart of the team's 4-bit ripple up counter. It is used wherever a loaded value must be counted down to zero, for example delay timers, periodic tick generators, and cascaded prescalers. All state changes on the rising edge of the single clock; no internal clock is derived from counter bits.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  loads load_val into count and reload register; starts a run
- load_val  input  WIDTH  value to load
- en  input  1  count enable; one decrement step per enabled cycle while running
- auto_reload  input  1  1 = reload on terminal event, 0 = one-shot stop
- q  output  WIDTH  current count (registered)
- zero  output  1  combinational, q == 0
- busy  output  1  registered, 1 while state is RUN
- tc  output  1  registered one-cycle pulse, high in the cycle after a terminal event
- done  output  1  registered, sticky one-shot completion flag

## Operation
- State machine with two states: IDLE and RUN. busy = (state == RUN).
- Internal reload register rl[WIDTH-1:0] holds the last loaded value.
- Priority at each rising edge: reset (async) > load > en.
- load=1, from any state: q←load_val, rl←load_val, state←RUN, done←0, tc←0. en is ignored that cycle, so no decrement occurs.
- RUN, load=0, en=1, q≠0: q←q−1 (modulo 2^WIDTH, but it never underflows here).
- RUN, load=0, en=1, q=0: this is a terminal event and tc←1 next cycle.
  - auto_reload=1: q←rl, state stays RUN.
  - auto_reload=0: q holds 0, state←IDLE, done←1.
  - auto_reload is sampled only at the event edge.
- RUN, en=0: q, state and done hold; tc←0.
- IDLE: en has no effect; q holds; tc←0. Only load leaves IDLE.
- Terminal period: from load to terminal event takes load_val+1 enabled cycles. In auto-reload mode, successive tc pulses are rl+1 enabled cycles apart.
- load_val=0 is legal. The first enabled cycle is a terminal event. With auto_reload=1 and rl=0, tc pulses on every enabled cycle.
- Cascading: the tc of one instance drives the en of the next instance, giving a prescaler chain.

## Timing
- Reset values (asynchronous, immediate): q=0, rl=0, state=IDLE, busy=0, tc=0, done=0, zero=1.
- Reset asserted mid-run aborts the run immediately with no tc pulse. After release, the block stays IDLE until a load.
- Load latency: q shows load_val one cycle after the load edge; busy=1 in that same cycle.
- Decrement latency: one cycle per enabled edge.
- tc is high for exactly one cycle after each terminal event and is never high for two consecutive cycles unless consecutive events occur (rl=0, auto-reload, en held high).
- done rises in the same cycle as the tc pulse for a one-shot event. It stays high until load or reset.
- Simultaneous load and terminal event: load wins, with no tc and no done.

## Test plan
- Reset then hold: assert reset mid-count at q=5 → q=0, busy=0, tc=0, done=0 immediately, and these hold after release with en=1.
- One-shot: load 3, auto_reload=0, en=1 constant → q sequence 3,2,1,0; the next edge gives tc=1 for one cycle, done=1, busy=0, and q stays 0 afterwards.
- Auto-reload: load 2, auto_reload=1, en=1 → q sequence 2,1,0,2,1,0,…; tc pulses every 3 cycles; done stays 0; busy stays 1.
- Enable gating: load 4, en toggled 1,0,1,0 → q decrements only on enabled edges; the terminal event occurs on the 5th enabled edge.
- Load priority: at q=0 in RUN, assert load=1 (load_val=7), en=1, auto_reload=0 → q=7, tc=0, done=0, busy=1.
- Edge values: with WIDTH=4, load 15 under auto-reload → tc period of 16 cycles. Load 0 under auto-reload → tc high every cycle while en=1.

Source files
------------

// File: rtl/bit_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : bit_down_counter
// Purpose  : Parameterised down counter with parallel load, count enable,
//            one-shot / auto-reload modes, terminal-count pulse and a sticky
//            one-shot completion flag.
// Revision : 1.0 - initial release
// ============================================================================
module bit_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rl, rl_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             done_nxt;

  // State and datapath registers; reset aborts any run without a tc pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      rl    <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rl    <= rl_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic: load beats count enable; a terminal event is an
  // enabled edge while running with the count already at zero.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    rl_nxt    = rl;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      state_nxt = RUN;
      q_nxt     = load_val;
      rl_nxt    = load_val;
      done_nxt  = 1'b0;
    end else if ((state == RUN) && en) begin
      if (q != '0) begin
        q_nxt = q - 1'b1;
      end else begin
        tc_nxt = 1'b1;
        if (auto_reload) begin
          q_nxt = rl;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign zero = (q == '0);

endmodule
`default_nettype wire

// File: tb/tb_bit_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_down_counter
// Purpose  : Self-checking bench for bit_down_counter: behavioural model
//            compared every cycle, directed literal checks, random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] q;
  logic       zero, busy, tc, done;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int  m_q, m_rl;
  bit  m_run, m_tc, m_done;

  bit_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .q(q), .zero(zero), .busy(busy), .tc(tc),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("q",    int'(q),    m_q);
    chk("zero", int'(zero), (m_q == 0) ? 1 : 0);
    chk("busy", int'(busy), int'(m_run));
    chk("tc",   int'(tc),   int'(m_tc));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic model_reset();
    m_q = 0; m_rl = 0; m_run = 0; m_tc = 0; m_done = 0;
  endtask

  // One clock: drive inputs, advance the model by the rules, compare after edge.
  task automatic step(input bit ld, input int lv, input bit e, input bit ar);
    load = ld; load_val = lv[3:0]; en = e; auto_reload = ar;
    @(posedge clk);
    m_tc = 0;
    if (ld) begin
      m_q = lv % 16; m_rl = lv % 16; m_run = 1; m_done = 0;
    end else if (m_run && e) begin
      if (m_q > 0) m_q = m_q - 1;
      else begin
        m_tc = 1;
        if (ar) m_q = m_rl;
        else begin m_run = 0; m_done = 1; end
      end
    end
    #1;
    compare_model();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int tc_cnt, first, second, en_edges;
    reset = 1'b1; load = 0; load_val = 0; en = 0; auto_reload = 0;
    model_reset();
    #12;
    chk("rst_q", int'(q), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_busy", int'(busy), 0);
    compare_model();
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-run at q=5, then stays idle with en=1
    step(1, 5, 0, 0);
    chk("pre_rst_q", int'(q), 5);
    async_reset();
    chk("midrst_q", int'(q), 0);
    chk("midrst_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      chk("hold_q", int'(q), 0);
      chk("hold_tc", int'(tc), 0);
    end

    // One-shot load 3
    step(1, 3, 1, 0); chk("os_q3", int'(q), 3); chk("os_busy", int'(busy), 1);
    step(0, 0, 1, 0); chk("os_q2", int'(q), 2);
    step(0, 0, 1, 0); chk("os_q1", int'(q), 1);
    step(0, 0, 1, 0); chk("os_q0", int'(q), 0); chk("os_tc_early", int'(tc), 0);
    step(0, 0, 1, 0);
    chk("os_tc", int'(tc), 1); chk("os_done", int'(done), 1); chk("os_idle", int'(busy), 0);
    step(0, 0, 1, 0);
    chk("os_tc_off", int'(tc), 0); chk("os_q_hold", int'(q), 0); chk("os_done_hold", int'(done), 1);

    // Auto-reload load 2: 2,1,0,2,1,0
    step(1, 2, 1, 1);
    step(0, 0, 1, 1); chk("ar_q1", int'(q), 1);
    step(0, 0, 1, 1); chk("ar_q0", int'(q), 0);
    step(0, 0, 1, 1); chk("ar_q2", int'(q), 2); chk("ar_tc", int'(tc), 1);
    chk("ar_done", int'(done), 0); chk("ar_busy", int'(busy), 1);

    // Enable gating: load 4, en alternating; tc after 5th enabled edge
    step(1, 4, 0, 0);
    en_edges = 0;
    for (int i = 0; i < 20 && !tc; i++) begin
      step(0, 0, (i % 2) == 0, 0);
      if ((i % 2) == 0) en_edges++;
    end
    chk("gate_edges", en_edges, 5);
    chk("gate_tc", int'(tc), 1);

    // Load priority at q=0 in RUN
    step(1, 0, 0, 0); chk("lp_q0", int'(q), 0);
    step(1, 7, 1, 0);
    chk("lp_q", int'(q), 7); chk("lp_tc", int'(tc), 0);
    chk("lp_done", int'(done), 0); chk("lp_busy", int'(busy), 1);

    // Auto-reload 15: tc period 16
    step(1, 15, 1, 1);
    first = -1; second = -1;
    for (int i = 0; i < 60 && second < 0; i++) begin
      step(0, 0, 1, 1);
      if (tc) begin
        if (first < 0) first = i; else second = i;
      end
    end
    chk("ar15_first", first, 15);
    chk("ar15_period", second - first, 16);

    // Auto-reload 0: tc every enabled cycle
    step(1, 0, 1, 1);
    tc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1);
      if (tc) tc_cnt++;
    end
    chk("ar0_tc_cnt", tc_cnt, 5);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      step($urandom_range(0, 9) == 0, $urandom_range(0, 15),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
